// File: rtl/calc_arbiter.sv
// calc_arbiter
// Arbitrates two requesters onto one shared combinational calculator
// (CombCalc). A request is accepted in IDLE, its operands are registered
// onto calc_op/calc_a/calc_b, and the calculator output is captured one
// cycle later. The result is then held in RESP until the consumer takes it.
// On contention the requester that was not served last wins (round-robin).
//
// Ports
//   CLOCK_50, RESET_N          clock, asynchronous active-low reset
//   reqN_valid/op/a/b          requester N operation (N = 0, 1)
//   reqN_ready                 combinational accept strobe for requester N
//   rsp_valid/ready/id/r/ovf   result handshake, owner id, result, overflow
//   calc_op/a/b                registered drive to the shared CombCalc
//   calc_r, calc_ovf           CombCalc combinational result
//   clr_err                    synchronous clear of err_count
//   err_count                  saturating count of overflowed operations
//   busy                       high whenever the FSM is not in IDLE
module calc_arbiter #(
  parameter int W = 4
) (
  input  logic         CLOCK_50,
  input  logic         RESET_N,
  input  logic         req0_valid,
  input  logic [2:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [2:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_r,
  output logic         rsp_ovf,
  output logic [2:0]   calc_op,
  output logic [W-1:0] calc_a,
  output logic [W-1:0] calc_b,
  input  logic [W-1:0] calc_r,
  input  logic         calc_ovf,
  input  logic         clr_err,
  output logic [7:0]   err_count,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         last_q, last_d;       // id of the requester served last
  logic         id_q, id_d;
  logic [2:0]   calc_op_q, calc_op_d;
  logic [W-1:0] calc_a_q, calc_a_d;
  logic [W-1:0] calc_b_q, calc_b_d;
  logic [W-1:0] rsp_r_q, rsp_r_d;
  logic         rsp_ovf_q, rsp_ovf_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         busy_q, busy_d;
  logic [7:0]   err_q, err_d;

  logic gnt0, gnt1;

  // A lone valid requester always wins; on contention the one not served
  // last wins. last_q resets to 1 so requester 0 has priority after reset.
  assign gnt0 = req0_valid && (!req1_valid || last_q);
  assign gnt1 = req1_valid && (!req0_valid || !last_q);

  assign req0_ready = (state_q == IDLE) && gnt0;
  assign req1_ready = (state_q == IDLE) && gnt1;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    calc_op_d = calc_op_q;
    calc_a_d  = calc_a_q;
    calc_b_d  = calc_b_q;
    rsp_r_d   = rsp_r_q;
    rsp_ovf_d = rsp_ovf_q;
    err_d     = err_q;

    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          calc_op_d = req0_op;
          calc_a_d  = req0_a;
          calc_b_d  = req0_b;
          id_d      = 1'b0;
          state_d   = EXEC;
        end else if (req1_ready) begin
          calc_op_d = req1_op;
          calc_a_d  = req1_a;
          calc_b_d  = req1_b;
          id_d      = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        // calc_r/calc_ovf are a pure function of the registered operands,
        // so they are settled one cycle after the accept.
        rsp_r_d   = calc_r;
        rsp_ovf_d = calc_ovf;
        if (calc_ovf && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear wins over a simultaneous overflow increment.
    if (clr_err) begin
      err_d = 8'd0;
    end
  end

  // Status outputs are registered from the next-state value so they line
  // up exactly with the state they describe.
  assign rsp_valid_d = (state_d == RESP);
  assign busy_d      = (state_d != IDLE);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      calc_op_q   <= 3'd0;
      calc_a_q    <= '0;
      calc_b_q    <= '0;
      rsp_r_q     <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      calc_op_q   <= calc_op_d;
      calc_a_q    <= calc_a_d;
      calc_b_q    <= calc_b_d;
      rsp_r_q     <= rsp_r_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign calc_op   = calc_op_q;
  assign calc_a    = calc_a_q;
  assign calc_b    = calc_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign err_count = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_calc_arbiter.sv
module tb_calc_arbiter;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N;
  logic       req0_valid, req1_valid;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_ready, req1_ready;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_ovf;
  logic [3:0] rsp_r;
  logic [2:0] calc_op;
  logic [3:0] calc_a, calc_b, calc_r;
  logic       calc_ovf;
  logic       clr_err;
  logic [7:0] err_count;
  logic       busy;

  int total = 0;
  int bad   = 0;

  calc_arbiter #(.W(4)) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .req0_valid (req0_valid),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_r      (rsp_r),
    .rsp_ovf    (rsp_ovf),
    .calc_op    (calc_op),
    .calc_a     (calc_a),
    .calc_b     (calc_b),
    .calc_r     (calc_r),
    .calc_ovf   (calc_ovf),
    .clr_err    (clr_err),
    .err_count  (err_count),
    .busy       (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Stand-in CombCalc: 001 add, 010 subtract (signed overflow), else xor.
  always_comb begin
    calc_r   = calc_a ^ calc_b;
    calc_ovf = 1'b0;
    case (calc_op)
      3'b001: begin
        calc_r   = calc_a + calc_b;
        calc_ovf = (calc_a[3] == calc_b[3]) && (calc_r[3] != calc_a[3]);
      end
      3'b010: begin
        calc_r   = calc_a - calc_b;
        calc_ovf = (calc_a[3] != calc_b[3]) && (calc_r[3] != calc_a[3]);
      end
      default: ;
    endcase
  end

  typedef struct {
    logic       v0;
    logic       v1;
    logic [2:0] op0;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [2:0] op1;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       rdy0;
    logic       rdy1;
    logic       id;
    logic [3:0] r;
    logic       ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // From IDLE at posedge+1: issue one op on requester 0, end back in IDLE.
  task automatic run_op0(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
  endtask

  // Overflowing op with clr_err raised on the EXEC capture edge.
  task automatic clr_during_exec(input string nm);
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 4'h7; req0_b = 4'h1;
    tick();
    req0_valid = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge CLOCK_50);
    chk(nm, int'(err_count), 0);
    chk({nm, "_ovf"}, int'(rsp_ovf), 1);
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 3'b001, 4'h3, 4'h2, 3'b000, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h5, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 3'b001, 4'h1, 4'h1, 3'b010, 4'h5, 4'h7, 1'b0, 1'b1, 1'b1, 4'hE, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 3'b001, 4'h7, 4'h1, 3'b001, 4'h2, 4'h2, 1'b1, 1'b0, 1'b0, 4'h8, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 3'b000, 4'h0, 4'h0, 3'b100, 4'hA, 4'h5, 1'b0, 1'b1, 1'b1, 4'hF, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 3'b010, 4'h8, 4'h1, 3'b000, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h7, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 3'b011, 4'h3, 4'h3, 3'b001, 4'h4, 4'h4, 1'b0, 1'b1, 1'b1, 4'h8, 1'b1};

    RESET_N = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 3'd0; req0_a = 4'h0; req0_b = 4'h0;
    req1_op = 3'd0; req1_a = 4'h0; req1_b = 4'h0;
    rsp_ready = 1'b1;
    clr_err = 1'b0;
    #1;
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_count), 0);
    chk("rst_calc_op", int'(calc_op), 0);
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1'b1;

    // Table-driven single operations, round-robin pointer carried across rows.
    for (int i = 0; i < 6; i++) begin
      tick();
      req0_valid = vecs[i].v0; req0_op = vecs[i].op0; req0_a = vecs[i].a0; req0_b = vecs[i].b0;
      req1_valid = vecs[i].v1; req1_op = vecs[i].op1; req1_a = vecs[i].a1; req1_b = vecs[i].b1;
      @(negedge CLOCK_50);
      chk($sformatf("v%0d_rdy0", i), int'(req0_ready), int'(vecs[i].rdy0));
      chk($sformatf("v%0d_rdy1", i), int'(req1_ready), int'(vecs[i].rdy1));
      chk($sformatf("v%0d_busy_idle", i), int'(busy), 0);
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge CLOCK_50);
      chk($sformatf("v%0d_busy_exec", i), int'(busy), 1);
      chk($sformatf("v%0d_rsp_valid_exec", i), int'(rsp_valid), 0);
      chk($sformatf("v%0d_calc_op", i), int'(calc_op), vecs[i].id ? int'(vecs[i].op1) : int'(vecs[i].op0));
      chk($sformatf("v%0d_calc_a", i), int'(calc_a), vecs[i].id ? int'(vecs[i].a1) : int'(vecs[i].a0));
      chk($sformatf("v%0d_calc_b", i), int'(calc_b), vecs[i].id ? int'(vecs[i].b1) : int'(vecs[i].b0));
      tick();
      @(negedge CLOCK_50);
      chk($sformatf("v%0d_rsp_valid", i), int'(rsp_valid), 1);
      chk($sformatf("v%0d_rsp_id", i), int'(rsp_id), int'(vecs[i].id));
      chk($sformatf("v%0d_rsp_r", i), int'(rsp_r), int'(vecs[i].r));
      chk($sformatf("v%0d_rsp_ovf", i), int'(rsp_ovf), int'(vecs[i].ovf));
      tick();
      @(negedge CLOCK_50);
      chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
      chk($sformatf("v%0d_idle_rsp_valid", i), int'(rsp_valid), 0);
    end
    chk("table_err_count", int'(err_count), 3);

    // Contention: both valid continuously, grants alternate 0,1,0,1.
    tick();
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 4'h1; req0_b = 4'h2;
    req1_valid = 1'b1; req1_op = 3'b100; req1_a = 4'h3; req1_b = 4'h5;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLOCK_50);
      chk($sformatf("cont%0d_rdy0", k), int'(req0_ready), (k % 2 == 0) ? 1 : 0);
      chk($sformatf("cont%0d_rdy1", k), int'(req1_ready), (k % 2 == 1) ? 1 : 0);
      tick();
      @(negedge CLOCK_50);
      chk($sformatf("cont%0d_busy", k), int'(busy), 1);
      tick();
      @(negedge CLOCK_50);
      chk($sformatf("cont%0d_rsp_id", k), int'(rsp_id), k % 2);
      chk($sformatf("cont%0d_rsp_r", k), int'(rsp_r), (k % 2 == 0) ? 3 : 6);
      if (k == 3) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      tick();
    end

    // Backpressure: hold RESP for 5 cycles with both requesters pushing.
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 4'h2; req0_b = 4'h3;
    rsp_ready = 1'b0;
    @(negedge CLOCK_50);
    chk("bp_accept", int'(req0_ready), 1);
    tick();
    req0_valid = 1'b0;
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge CLOCK_50);
      chk($sformatf("bp%0d_rsp_valid", c), int'(rsp_valid), 1);
      chk($sformatf("bp%0d_rsp_r", c), int'(rsp_r), 5);
      chk($sformatf("bp%0d_rsp_id", c), int'(rsp_id), 0);
      chk($sformatf("bp%0d_rdy0", c), int'(req0_ready), 0);
      chk($sformatf("bp%0d_rdy1", c), int'(req1_ready), 0);
      tick();
    end
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge CLOCK_50);
    chk("bp_release_rsp_valid", int'(rsp_valid), 1);
    tick();
    @(negedge CLOCK_50);
    chk("bp_idle_rsp_valid", int'(rsp_valid), 0);
    chk("bp_idle_busy", int'(busy), 0);
    tick();

    // Withdrawn request: req1 pulses for one cycle during EXEC only.
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 4'h1; req0_b = 4'h1;
    @(negedge CLOCK_50);
    chk("wd_rdy0", int'(req0_ready), 1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b1;
    @(negedge CLOCK_50);
    chk("wd_rdy1_exec", int'(req1_ready), 0);
    tick();
    req1_valid = 1'b0;
    @(negedge CLOCK_50);
    chk("wd_rsp_id", int'(rsp_id), 0);
    chk("wd_rsp_r", int'(rsp_r), 2);
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge CLOCK_50);
      chk($sformatf("wd%0d_busy", c), int'(busy), 0);
      chk($sformatf("wd%0d_rsp_valid", c), int'(rsp_valid), 0);
      tick();
    end

    // Overflow counting and clear.
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge CLOCK_50);
    chk("clr_idle", int'(err_count), 0);
    tick();
    for (int i = 0; i < 257; i++) begin
      run_op0(3'b001, 4'h7, 4'h1);
      if (i == 253) begin
        @(negedge CLOCK_50);
        chk("err_254", int'(err_count), 8'hFE);
        tick();
      end
    end
    @(negedge CLOCK_50);
    chk("err_sat", int'(err_count), 8'hFF);
    tick();
    clr_during_exec("clr_vs_inc_sat");
    run_op0(3'b001, 4'h7, 4'h1);
    @(negedge CLOCK_50);
    chk("err_after_clr", int'(err_count), 1);
    tick();
    clr_during_exec("clr_vs_inc");

    // Reset mid-RESP, then req1-only granted first time after release.
    req1_valid = 1'b1; req1_op = 3'b001; req1_a = 4'h7; req1_b = 4'h7;
    rsp_ready = 1'b0;
    tick();
    req1_valid = 1'b0;
    tick();
    @(negedge CLOCK_50);
    chk("pre_rst_rsp_valid", int'(rsp_valid), 1);
    chk("pre_rst_rsp_id", int'(rsp_id), 1);
    chk("pre_rst_err", int'(err_count), 1);
    #2;
    RESET_N = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
    chk("mid_rst_rsp_id", int'(rsp_id), 0);
    chk("mid_rst_rsp_r", int'(rsp_r), 0);
    chk("mid_rst_rsp_ovf", int'(rsp_ovf), 0);
    chk("mid_rst_calc_op", int'(calc_op), 0);
    chk("mid_rst_calc_a", int'(calc_a), 0);
    chk("mid_rst_calc_b", int'(calc_b), 0);
    chk("mid_rst_err", int'(err_count), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_rdy0", int'(req0_ready), 1);
    chk("mid_rst_rdy1", int'(req1_ready), 0);
    req0_valid = 1'b0;
    #1;
    chk("mid_rst_rdy1_only", int'(req1_ready), 1);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    tick();
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge CLOCK_50);
    chk("post_rst_busy", int'(busy), 1);
    chk("post_rst_calc_a", int'(calc_a), 7);
    tick();
    @(negedge CLOCK_50);
    chk("post_rst_rsp_valid", int'(rsp_valid), 1);
    chk("post_rst_rsp_id", int'(rsp_id), 1);
    chk("post_rst_rsp_r", int'(rsp_r), 4'hE);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
